io_bus_arbiter: RTL and testbench
=================================

// Module: io_bus_arbiter
// PURPOSE
//  Shares the single IO bus (dev_sel/reg_sel/we/data_in/data_out) of the LogicaIO block between two masters.
//  M0 is the Maquina Sencilla core; M1 is the debug/DMA port.
//  Round-robin arbitration; one transfer per grant, with programmable wait states; req/ack handshake per master.
//  Sits between the masters and LogicaIO; LogicaIO itself is unchanged.
// PARAMETERS
//  WAIT_CYC  1     bus cycles the access phase lasts (1..15); read data captured on the last one
//  IDLE_DEV  3'd7  dev_sel driven when no transfer is active (unmapped device, no side effects)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high
//  req0/req1    in   1   transfer request; must be held until the matching ack
//  we0/we1      in   1   1 = write, 0 = read
//  dev0/dev1    in   3   target device select
//  reg0/reg1    in   2   target register select
//  wdata0/1     in   16  write data
//  ack0/ack1    out  1   one-cycle pulse: transfer complete
//  rdata0/1     out  16  read data; valid in the ack cycle and held until that master's next ack
//  io_dev_sel   out  3   to LogicaIO dev_sel
//  io_reg_sel   out  2   to LogicaIO reg_sel
//  io_we        out  1   to LogicaIO we
//  io_data_in   out  16  to LogicaIO data_in
//  io_data_out  in   16  from LogicaIO data_out (combinational)
//  owner        out  1   master currently or last granted (debug)
// BEHAVIOUR
//  Reset values:
//    ack0/1 = 0; rdata0/1 = 0; io_dev_sel = IDLE_DEV; io_reg_sel = 0; io_we = 0; io_data_in = 0
//    owner = 1, so M0 wins the first tie; state = IDLE; wait counter = 0
//  FSM IDLE -> ACCESS -> DONE -> IDLE:
//    IDLE:   if any req, pick a winner (see arbitration), latch its we/dev/reg/wdata into bus registers,
//            go to ACCESS.
//    ACCESS: bus registers drive io_*; io_we is high for exactly ONE cycle (the first ACCESS cycle),
//            so LED/button writes fire once. The counter runs WAIT_CYC cycles. On the last cycle,
//            io_data_out is sampled into the winner's rdata (reads only; writes leave rdata unchanged).
//            Go to DONE.
//    DONE:   ack of the winner = 1; io_dev_sel = IDLE_DEV; io_we = 0; go to IDLE.
//  Latency:
//    req seen high in an IDLE cycle n -> ack in cycle n+1+WAIT_CYC
//    Back-to-back transfers: one IDLE cycle between them (peak throughput 1 per WAIT_CYC+2).
//  Arbitration:
//    Only one requester: it wins.
//    Both requesting: the master != owner wins; owner updates to the winner on entering ACCESS.
//  Boundaries:
//    Winner drops req during ACCESS: the transfer still completes and ack is still issued.
//    The loser's req is not lost; it is re-evaluated in the next IDLE.
//    Master inputs change during ACCESS: ignored, because they were latched in IDLE.
//    Reset mid-ACCESS: io_we and acks drop immediately (async); no partial ack is ever issued.
//    WAIT_CYC = 0 or > 15: treated as 1 (elaboration-time clamp).
// CONFIGURATION
//  IO_ARB_LOCK_EN defined:
//    Adds inputs lock0/lock1 (1 bit).
//    If the winner's lock is high in its ack cycle, the next IDLE grants only that master;
//      the other master's req is ignored until a transfer completes with lock = 0.
//    lock is sampled only in the ack cycle.
//  IO_ARB_LOCK_EN not defined:
//    No lock ports; pure round-robin.
// STRUCTURE
//  Shared include io_defs.vh holds:
//    FSM state encodings (S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2)
//    IO device IDs (DEV_LED = 0, DEV_SW = 1, DEV_BTN = 2, DEV_NONE = 7)
//  One natural sub-module: io_rr_pick.
//    Combinational: req0, req1, owner, lock state -> grant_valid, grant_id.
//    Keeps the fairness logic testable on its own.
// TESTING
//  1. Reset, then M0 writes dev0 = 0, wdata0 = 16'h00A5 -> io_we high exactly 1 cycle with io_data_in = 16'h00A5;
//     ack0 at n+2 (WAIT_CYC = 1).
//  2. M1 reads dev1 = 1 with io_data_out = 16'h003C -> rdata1 = 16'h003C in the ack1 cycle;
//     rdata0 unchanged.
//  3. req0 and req1 held high for 6 transfers -> grants alternate M0, M1, M0, M1, M0, M1;
//     never two acks in the same cycle.
//  4. WAIT_CYC = 3, read -> io_dev_sel held for 3 cycles; data sampled on the 3rd; ack at n+4.
//  5. Assert reset during ACCESS of a write -> io_we = 0 and ack = 0 immediately;
//     all outputs at reset values; owner = 1.
//  6. (IO_ARB_LOCK_EN) M0 does 3 locked writes with req1 high -> M1 is not acked until
//     after M0's first transfer with lock0 = 0.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// Shared FSM state encoding, LogicaIO device IDs and the wait-state clamp
// used by the IO bus arbiter.
package io_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } arb_state_t;

  localparam logic [2:0] DEV_LED  = 3'd0;
  localparam logic [2:0] DEV_SW   = 3'd1;
  localparam logic [2:0] DEV_BTN  = 3'd2;
  localparam logic [2:0] DEV_NONE = 3'd7;

  // Out-of-range wait-state counts fall back to a single access cycle.
  function automatic int clamp_wait(input int cyc);
    return (cyc < 1 || cyc > 15) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational round-robin pick between the two bus masters, with an
// optional lock that restricts the grant to the locking master.
module io_bus_arbiter_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  input  logic lock_active,
  input  logic lock_id,
  output logic grant_valid,
  output logic grant_id
);

  logic eff0;
  logic eff1;

  // A held lock masks the other master; a tie goes to the master that is not the owner.
  always_comb begin
    eff0        = req0 & ~(lock_active & lock_id);
    eff1        = req1 & ~(lock_active & ~lock_id);
    grant_valid = eff0 | eff1;
    grant_id    = (eff0 & eff1) ? ~owner : eff1;
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter in front of the LogicaIO register bus.
// Define IO_ARB_LOCK_EN to add lock0/lock1 for locked back-to-back transfers.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int         WAIT_CYC = 1,
  parameter logic [2:0] IDLE_DEV = DEV_NONE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [2:0]  dev0,
  input  logic [2:0]  dev1,
  input  logic [1:0]  reg0,
  input  logic [1:0]  reg1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
`ifdef IO_ARB_LOCK_EN
  input  logic        lock0,
  input  logic        lock1,
`endif
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [2:0]  io_dev_sel,
  output logic [1:0]  io_reg_sel,
  output logic        io_we,
  output logic [15:0] io_data_in,
  input  logic [15:0] io_data_out,
  output logic        owner
);

  localparam int         WAIT_EFF = clamp_wait(WAIT_CYC);
  localparam logic [3:0] LAST_CNT = 4'(WAIT_EFF - 1);

  arb_state_t state;
  arb_state_t next_state;
  logic [3:0] wait_cnt;
  logic       bus_we;
  logic       grant_valid;
  logic       grant_id;
  logic       lock_active;
  logic       lock_id;
  logic       last_cyc;

  assign last_cyc = (wait_cnt == LAST_CNT);

  io_bus_arbiter_rr_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .owner       (owner),
    .lock_active (lock_active),
    .lock_id     (lock_id),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // The ack is a pure function of state so an async reset can never leave a partial pulse.
  always_comb begin
    next_state = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    case (state)
      S_IDLE:   if (grant_valid) next_state = S_ACCESS;
      S_ACCESS: if (last_cyc) next_state = S_DONE;
      S_DONE: begin
        next_state = S_IDLE;
        ack0       = ~owner;
        ack1       = owner;
      end
      default:  next_state = S_IDLE;
    endcase
  end

  // owner doubles as the current winner, since it is updated on every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b1;
      wait_cnt   <= 4'd0;
      bus_we     <= 1'b0;
      io_dev_sel <= IDLE_DEV;
      io_reg_sel <= 2'd0;
      io_we      <= 1'b0;
      io_data_in <= 16'd0;
      rdata0     <= 16'd0;
      rdata1     <= 16'd0;
    end else begin
      io_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            owner      <= grant_id;
            wait_cnt   <= 4'd0;
            bus_we     <= grant_id ? we1 : we0;
            io_we      <= grant_id ? we1 : we0;
            io_dev_sel <= grant_id ? dev1 : dev0;
            io_reg_sel <= grant_id ? reg1 : reg0;
            io_data_in <= grant_id ? wdata1 : wdata0;
          end
        end
        S_ACCESS: begin
          if (last_cyc) begin
            wait_cnt   <= 4'd0;
            io_dev_sel <= IDLE_DEV;
            if (!bus_we) begin
              if (owner) rdata1 <= io_data_out;
              else       rdata0 <= io_data_out;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IO_ARB_LOCK_EN
  // The winner's lock is captured only in its ack cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_id     <= 1'b0;
    end else if (state == S_DONE) begin
      lock_active <= owner ? lock1 : lock0;
      lock_id     <= owner;
    end
  end
`else
  assign lock_active = 1'b0;
  assign lock_id     = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: two instances (WAIT_CYC 1 and 3) share
// the master inputs and are checked every cycle against a transaction-level model.
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  localparam int NI = 2;
`ifdef IO_ARB_LOCK_EN
  localparam bit HAS_LOCK = 1'b1;
`else
  localparam bit HAS_LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic lock0 = 1'b0, lock1 = 1'b0;
  logic [2:0] dev0 = 3'd0, dev1 = 3'd0;
  logic [1:0] reg0 = 2'd0, reg1 = 2'd0;
  logic [15:0] wdata0 = 16'd0, wdata1 = 16'd0;

  logic        ack0_v [NI];
  logic        ack1_v [NI];
  logic        io_we_v [NI];
  logic        owner_v [NI];
  logic [15:0] rdata0_v [NI];
  logic [15:0] rdata1_v [NI];
  logic [15:0] io_data_in_v [NI];
  logic [15:0] dout_v [NI];
  logic [2:0]  io_dev_sel_v [NI];
  logic [1:0]  io_reg_sel_v [NI];

  // Transaction-level model: cycle index, grant cycle and latched request per instance.
  int          m_cyc [NI];
  int          m_nxt_idle [NI];
  int          m_g [NI];
  logic        m_own [NI];
  logic        m_we [NI];
  logic [2:0]  m_dev [NI];
  logic [1:0]  m_reg [NI];
  logic [15:0] m_wd [NI];
  logic [15:0] m_rd0 [NI];
  logic [15:0] m_rd1 [NI];
  logic        m_lock_on [NI];
  logic        m_lock_who [NI];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.WAIT_CYC(1)) u_dut_w1 (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .dev0(dev0), .dev1(dev1), .reg0(reg0), .reg1(reg1),
    .wdata0(wdata0), .wdata1(wdata1),
`ifdef IO_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .ack0(ack0_v[0]), .ack1(ack1_v[0]),
    .rdata0(rdata0_v[0]), .rdata1(rdata1_v[0]),
    .io_dev_sel(io_dev_sel_v[0]), .io_reg_sel(io_reg_sel_v[0]),
    .io_we(io_we_v[0]), .io_data_in(io_data_in_v[0]),
    .io_data_out(dout_v[0]), .owner(owner_v[0])
  );

  io_bus_arbiter #(.WAIT_CYC(3)) u_dut_w3 (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .dev0(dev0), .dev1(dev1), .reg0(reg0), .reg1(reg1),
    .wdata0(wdata0), .wdata1(wdata1),
`ifdef IO_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .ack0(ack0_v[1]), .ack1(ack1_v[1]),
    .rdata0(rdata0_v[1]), .rdata1(rdata1_v[1]),
    .io_dev_sel(io_dev_sel_v[1]), .io_reg_sel(io_reg_sel_v[1]),
    .io_we(io_we_v[1]), .io_data_in(io_data_in_v[1]),
    .io_data_out(dout_v[1]), .owner(owner_v[1])
  );

  function automatic int w_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] b16(input logic b);
    return {15'd0, b};
  endfunction

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_cyc[k] = 0;       m_nxt_idle[k] = 0;  m_g[k] = -100;
      m_own[k] = 1'b1;    m_we[k] = 1'b0;     m_dev[k] = 3'd0;
      m_reg[k] = 2'd0;    m_wd[k] = 16'd0;    m_rd0[k] = 16'd0;
      m_rd1[k] = 16'd0;   m_lock_on[k] = 1'b0; m_lock_who[k] = 1'b0;
    end
  endtask

  // Cycle c just ended: capture read data on the last access cycle, sample lock on
  // the ack cycle, and grant a new transfer if c was an idle cycle.
  task automatic model_step(input int k);
    int c, w;
    logic r0, r1, win;
    c = m_cyc[k];
    w = w_of(k);
    if (c == m_g[k] + w && !m_we[k]) begin
      if (m_own[k]) m_rd1[k] = dout_v[k];
      else          m_rd0[k] = dout_v[k];
    end
    if (HAS_LOCK && c == m_g[k] + w + 1) begin
      m_lock_on[k]  = m_own[k] ? lock1 : lock0;
      m_lock_who[k] = m_own[k];
    end
    if (c >= m_nxt_idle[k]) begin
      r0 = req0 && !(m_lock_on[k] && m_lock_who[k]);
      r1 = req1 && !(m_lock_on[k] && !m_lock_who[k]);
      if (r0 || r1) begin
        win           = (r0 && r1) ? !m_own[k] : r1;
        m_own[k]      = win;
        m_g[k]        = c;
        m_nxt_idle[k] = c + w + 2;
        m_we[k]       = win ? we1 : we0;
        m_dev[k]      = win ? dev1 : dev0;
        m_reg[k]      = win ? reg1 : reg0;
        m_wd[k]       = win ? wdata1 : wdata0;
      end
    end
    m_cyc[k] = c + 1;
  endtask

  task automatic compare_instance(input int k);
    int c, w;
    logic acc;
    string p;
    c   = m_cyc[k];
    w   = w_of(k);
    acc = (c > m_g[k]) && (c <= m_g[k] + w);
    p   = (k == 0) ? "w1" : "w3";
    check_output({p, ".ack0"}, b16(ack0_v[k]), b16((c == m_g[k] + w + 1) && !m_own[k]));
    check_output({p, ".ack1"}, b16(ack1_v[k]), b16((c == m_g[k] + w + 1) && m_own[k]));
    check_output({p, ".owner"}, b16(owner_v[k]), b16(m_own[k]));
    check_output({p, ".io_we"}, b16(io_we_v[k]), b16(acc && c == m_g[k] + 1 && m_we[k]));
    check_output({p, ".io_dev_sel"}, {13'd0, io_dev_sel_v[k]}, {13'd0, acc ? m_dev[k] : DEV_NONE});
    check_output({p, ".rdata0"}, rdata0_v[k], m_rd0[k]);
    check_output({p, ".rdata1"}, rdata1_v[k], m_rd1[k]);
    if (acc) begin
      check_output({p, ".io_reg_sel"}, {14'd0, io_reg_sel_v[k]}, {14'd0, m_reg[k]});
      check_output({p, ".io_data_in"}, io_data_in_v[k], m_wd[k]);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NI; k++) model_step(k);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) compare_instance(k);
  end

  function automatic logic [2:0] pick_dev();
    case ($urandom_range(0, 3))
      0:       return DEV_LED;
      1:       return DEV_SW;
      2:       return DEV_BTN;
      default: return DEV_NONE;
    endcase
  endfunction

  task automatic apply_stimulus();
    if ($urandom_range(0, 3) == 0) begin
      req0   = ($urandom_range(0, 3) != 0);
      we0    = 1'($urandom_range(0, 1));
      dev0   = pick_dev();
      reg0   = 2'($urandom_range(0, 3));
      wdata0 = 16'($urandom);
      lock0  = ($urandom_range(0, 3) == 0);
    end
    if ($urandom_range(0, 3) == 0) begin
      req1   = ($urandom_range(0, 3) != 0);
      we1    = 1'($urandom_range(0, 1));
      dev1   = pick_dev();
      reg1   = 2'($urandom_range(0, 3));
      wdata1 = 16'($urandom);
      lock1  = ($urandom_range(0, 3) == 0);
    end
    dout_v[0] = 16'($urandom);
    dout_v[1] = 16'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seq [8];
    int seq_len, n0, doubles;
    bit done, clr;

    model_reset();
    dout_v[0] = 16'd0;
    dout_v[1] = 16'd0;
    $display("[TB] start");

    // Reset values
    @(negedge clk);
    check_output("rst.owner", b16(owner_v[0]), 16'd1);
    check_output("rst.io_dev_sel", {13'd0, io_dev_sel_v[0]}, 16'd7);
    check_output("rst.io_we", b16(io_we_v[0]), 16'd0);
    check_output("rst.ack0", b16(ack0_v[0]), 16'd0);
    check_output("rst.io_data_in", io_data_in_v[0], 16'd0);
    check_output("rst.io_reg_sel", {14'd0, io_reg_sel_v[0]}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

    // M0 write of 0x00A5 to the LED device
    req0 = 1'b1; we0 = 1'b1; dev0 = DEV_LED; reg0 = 2'd1; wdata0 = 16'h00A5;
    @(negedge clk);
    check_output("t1.io_we", b16(io_we_v[0]), 16'd1);
    check_output("t1.io_data_in", io_data_in_v[0], 16'h00A5);
    check_output("t1.ack0_early", b16(ack0_v[0]), 16'd0);
    req0 = 1'b0;
    @(negedge clk);
    check_output("t1.ack0", b16(ack0_v[0]), 16'd1);
    check_output("t1.io_we_once", b16(io_we_v[0]), 16'd0);
    check_output("t1.io_dev_idle", {13'd0, io_dev_sel_v[0]}, 16'd7);
    @(negedge clk);
    check_output("t1.w3_ack0_early", b16(ack0_v[1]), 16'd0);
    @(negedge clk);
    check_output("t1.w3_ack0", b16(ack0_v[1]), 16'd1);
    idle_cycles(3);

    // M1 read from the switch device
    req1 = 1'b1; we1 = 1'b0; dev1 = DEV_SW; reg1 = 2'd0;
    dout_v[0] = 16'h003C; dout_v[1] = 16'h003C;
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    check_output("t2.ack1", b16(ack1_v[0]), 16'd1);
    check_output("t2.rdata1", rdata1_v[0], 16'h003C);
    check_output("t2.rdata0", rdata0_v[0], 16'h0000);
    idle_cycles(6);

    // Both masters held high: grants must alternate, starting with M0
    req0 = 1'b1; we0 = 1'b0; dev0 = DEV_BTN;
    req1 = 1'b1; we1 = 1'b1; dev1 = DEV_LED; wdata1 = 16'h1234;
    seq_len = 0; doubles = 0;
    for (int i = 0; i < 40 && seq_len < 6; i++) begin
      @(negedge clk);
      if (ack0_v[0] && ack1_v[0]) doubles++;
      if (ack0_v[0]) begin seq[seq_len] = 0; seq_len++; end
      else if (ack1_v[0]) begin seq[seq_len] = 1; seq_len++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check_output("t3.ack_count", 16'(seq_len), 16'd6);
    check_output("t3.double_ack", 16'(doubles), 16'd0);
    for (int i = 0; i < seq_len; i++)
      check_output($sformatf("t3.grant%0d", i), 16'(seq[i]), 16'(i % 2));
    idle_cycles(8);

    // WAIT_CYC=3 read: device held three cycles, data taken on the third
    req0 = 1'b1; we0 = 1'b0; dev0 = DEV_SW; reg0 = 2'd2; dout_v[1] = 16'h0000;
    @(negedge clk);
    req0 = 1'b0;
    check_output("t4.dev_c1", {13'd0, io_dev_sel_v[1]}, 16'd1);
    dout_v[1] = 16'h1111;
    @(negedge clk);
    check_output("t4.dev_c2", {13'd0, io_dev_sel_v[1]}, 16'd1);
    dout_v[1] = 16'h2222;
    @(negedge clk);
    check_output("t4.dev_c3", {13'd0, io_dev_sel_v[1]}, 16'd1);
    check_output("t4.ack0_early", b16(ack0_v[1]), 16'd0);
    dout_v[1] = 16'h3333;
    @(negedge clk);
    check_output("t4.ack0", b16(ack0_v[1]), 16'd1);
    check_output("t4.rdata0", rdata0_v[1], 16'h3333);
    check_output("t4.dev_idle", {13'd0, io_dev_sel_v[1]}, 16'd7);
    idle_cycles(3);

    // Reset in the middle of a write access
    req1 = 1'b1; we1 = 1'b1; dev1 = DEV_BTN; wdata1 = 16'h5A5A;
    @(negedge clk);
    check_output("t5.io_we_before", b16(io_we_v[0]), 16'd1);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check_output("t5.io_we", b16(io_we_v[0]), 16'd0);
    check_output("t5.w3_io_we", b16(io_we_v[1]), 16'd0);
    check_output("t5.ack1", b16(ack1_v[0]), 16'd0);
    check_output("t5.owner", b16(owner_v[0]), 16'd1);
    check_output("t5.io_dev_sel", {13'd0, io_dev_sel_v[0]}, 16'd7);
    check_output("t5.io_data_in", io_data_in_v[0], 16'd0);
    check_output("t5.rdata1", rdata1_v[0], 16'd0);
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

`ifdef IO_ARB_LOCK_EN
    // M0 holds the bus with three locked writes, then one unlocked, before M1 gets in
    req0 = 1'b1; we0 = 1'b1; dev0 = DEV_LED; lock0 = 1'b1;
    req1 = 1'b1; we1 = 1'b1; dev1 = DEV_LED; lock1 = 1'b0;
    seq_len = 0; n0 = 0; done = 1'b0; clr = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (clr) begin lock0 = 1'b0; clr = 1'b0; end
      if (ack0_v[0] && seq_len < 8) begin
        seq[seq_len] = 0; seq_len++; n0++;
        if (n0 == 3) clr = 1'b1;
        if (n0 == 4) req0 = 1'b0;
      end
      if (ack1_v[0] && seq_len < 8) begin
        seq[seq_len] = 1; seq_len++; done = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    check_output("t6.ack_count", 16'(seq_len), 16'd5);
    for (int i = 0; i < seq_len && i < 5; i++)
      check_output($sformatf("t6.grant%0d", i), 16'(seq[i]), (i == 4) ? 16'd1 : 16'd0);
    idle_cycles(8);
`endif

    // Randomized traffic with occasional resets, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) begin
        #1 reset = 1'b1;
        model_reset();
      end
      apply_stimulus();
    end
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    idle_cycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
